// File: rtl/spart_core_if.sv
// Processor-side register bus of the serial port: chip select, direction,
// register address, and the two status flags returned to the bus driver.
interface spart_core_if;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    logic       rda;
    logic       tbr;

    modport master (
        output iocs,
        output iorw,
        output ioaddr,
        input  rda,
        input  tbr
    );

    modport slave (
        input  iocs,
        input  iorw,
        input  ioaddr,
        output rda,
        output tbr
    );
endinterface

// File: rtl/spart_core.sv
// Serial port core: register decode on the processor bus, programmable baud
// divisor with 16x oversample enable, and an 8N1 transmitter and receiver.
module spart_core #(
    parameter logic [15:0] DIV_RESET  = 16'h0516,
    parameter int          OVERSAMPLE = 16
) (
    input  logic         clk,
    input  logic         rst,
    spart_core_if.slave  bus,
    inout  wire  [7:0]   databus,
    output logic         txd,
    input  logic         rxd
);

    localparam int              OS_W      = $clog2(OVERSAMPLE);
    localparam logic [OS_W-1:0] TICK_LAST = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0] TICK_MID  = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0] TICK_ONE  = OS_W'(1);

    // ---------------- bus decode ----------------
    logic wr, rd, wr_tx, wr_dlo, wr_dhi, rd_rx;
    assign wr     = bus.iocs && !bus.iorw;
    assign rd     = bus.iocs &&  bus.iorw;
    assign wr_tx  = wr && (bus.ioaddr == 2'b00);
    assign wr_dlo = wr && (bus.ioaddr == 2'b10);
    assign wr_dhi = wr && (bus.ioaddr == 2'b11);
    assign rd_rx  = rd && (bus.ioaddr == 2'b00);

    // ---------------- baud generator ----------------
    logic [15:0] divisor_reg, div_next, baud_cnt_reg;
    logic        baud_en;

    always_comb begin
        div_next = divisor_reg;
        if (wr_dlo) div_next[7:0]  = databus;
        if (wr_dhi) div_next[15:8] = databus;
    end

    // No enable in a divisor write cycle so the new rate starts cleanly.
    assign baud_en = (baud_cnt_reg == 16'd0) && !(wr_dlo || wr_dhi);

    always_ff @(posedge clk) begin
        if (rst) begin
            divisor_reg  <= DIV_RESET;
            baud_cnt_reg <= DIV_RESET;
        end else begin
            divisor_reg <= div_next;
            if (wr_dlo || wr_dhi)
                baud_cnt_reg <= div_next;
            else if (baud_cnt_reg == 16'd0)
                baud_cnt_reg <= divisor_reg;
            else
                baud_cnt_reg <= baud_cnt_reg - 16'd1;
        end
    end

    // ---------------- transmitter ----------------
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    tx_state_t       tx_state_reg;
    logic [OS_W-1:0] tx_tick_reg;
    logic [2:0]      tx_bit_reg;
    logic [7:0]      tx_buf_reg;
    logic            tbr_reg, txd_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_reg <= TX_IDLE;
            tx_tick_reg  <= '0;
            tx_bit_reg   <= 3'd0;
            tx_buf_reg   <= 8'h00;
            tbr_reg      <= 1'b1;
            txd_reg      <= 1'b1;
        end else begin
            if (wr_tx && tbr_reg) begin
                tx_buf_reg <= databus;
                tbr_reg    <= 1'b0;
            end
            case (tx_state_reg)
                TX_IDLE: begin
                    if (!tbr_reg && baud_en) begin
                        tx_state_reg <= TX_START;
                        tx_tick_reg  <= '0;
                        txd_reg      <= 1'b0;
                    end
                end
                TX_START: begin
                    if (baud_en) begin
                        if (tx_tick_reg == TICK_LAST) begin
                            tx_tick_reg  <= '0;
                            tx_bit_reg   <= 3'd0;
                            txd_reg      <= tx_buf_reg[0];
                            tx_state_reg <= TX_DATA;
                        end else begin
                            tx_tick_reg <= tx_tick_reg + TICK_ONE;
                        end
                    end
                end
                TX_DATA: begin
                    if (baud_en) begin
                        if (tx_tick_reg == TICK_LAST) begin
                            tx_tick_reg <= '0;
                            if (tx_bit_reg == 3'd7) begin
                                txd_reg      <= 1'b1;
                                tx_state_reg <= TX_STOP;
                            end else begin
                                tx_bit_reg <= tx_bit_reg + 3'd1;
                                txd_reg    <= tx_buf_reg[tx_bit_reg + 3'd1];
                            end
                        end else begin
                            tx_tick_reg <= tx_tick_reg + TICK_ONE;
                        end
                    end
                end
                TX_STOP: begin
                    if (baud_en) begin
                        if (tx_tick_reg == TICK_LAST) begin
                            tx_tick_reg  <= '0;
                            tbr_reg      <= 1'b1;
                            tx_state_reg <= TX_IDLE;
                        end else begin
                            tx_tick_reg <= tx_tick_reg + TICK_ONE;
                        end
                    end
                end
                default: tx_state_reg <= TX_IDLE;
            endcase
        end
    end

    // ---------------- receiver ----------------
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    rx_state_t       rx_state_reg;
    logic            rx_meta_reg, rx_sync_reg;
    logic [OS_W-1:0] rx_tick_reg;
    logic [2:0]      rx_bit_reg;
    logic [7:0]      rx_shift_reg, rx_buf_reg;
    logic            rda_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_reg <= RX_IDLE;
            rx_meta_reg  <= 1'b1;
            rx_sync_reg  <= 1'b1;
            rx_tick_reg  <= '0;
            rx_bit_reg   <= 3'd0;
            rx_shift_reg <= 8'h00;
            rx_buf_reg   <= 8'h00;
            rda_reg      <= 1'b0;
        end else begin
            rx_meta_reg <= rxd;
            rx_sync_reg <= rx_meta_reg;
            if (rd_rx) rda_reg <= 1'b0;
            case (rx_state_reg)
                RX_IDLE: begin
                    if (!rx_sync_reg) begin
                        rx_state_reg <= RX_START;
                        rx_tick_reg  <= '0;
                    end
                end
                RX_START: begin
                    if (baud_en) begin
                        if (rx_tick_reg == TICK_MID) begin
                            rx_tick_reg  <= '0;
                            rx_bit_reg   <= 3'd0;
                            rx_state_reg <= rx_sync_reg ? RX_IDLE : RX_DATA;
                        end else begin
                            rx_tick_reg <= rx_tick_reg + TICK_ONE;
                        end
                    end
                end
                RX_DATA: begin
                    if (baud_en) begin
                        if (rx_tick_reg == TICK_LAST) begin
                            rx_tick_reg  <= '0;
                            rx_shift_reg <= {rx_sync_reg, rx_shift_reg[7:1]};
                            if (rx_bit_reg == 3'd7)
                                rx_state_reg <= RX_STOP;
                            else
                                rx_bit_reg <= rx_bit_reg + 3'd1;
                        end else begin
                            rx_tick_reg <= rx_tick_reg + TICK_ONE;
                        end
                    end
                end
                RX_STOP: begin
                    if (baud_en) begin
                        if (rx_tick_reg == TICK_LAST) begin
                            rx_tick_reg  <= '0;
                            rx_state_reg <= RX_IDLE;
                            // A completing byte overrides a same-cycle read clear.
                            if (rx_sync_reg) begin
                                rx_buf_reg <= rx_shift_reg;
                                rda_reg    <= 1'b1;
                            end
                        end else begin
                            rx_tick_reg <= rx_tick_reg + TICK_ONE;
                        end
                    end
                end
                default: rx_state_reg <= RX_IDLE;
            endcase
        end
    end

    // ---------------- read mux and outputs ----------------
    logic [7:0] rdata;
    always_comb begin
        rdata = 8'h00;
        case (bus.ioaddr)
            2'b00:   rdata = rx_buf_reg;
            2'b01:   rdata = {6'b0, tbr_reg, rda_reg};
            default: rdata = 8'h00;
        endcase
    end

    assign databus = rd ? rdata : 8'hzz;
    assign bus.rda = rda_reg;
    assign bus.tbr = tbr_reg;
    assign txd     = txd_reg;

endmodule

// File: tb/tb_spart_core.sv
// Randomized bench for spart_core: bus accesses, TX frame capture and RX frame
// injection, checked against a frame-level model of the serial port.
module tb_spart_core;

    logic       clk = 1'b0;
    logic       rst;
    logic       txd;
    logic       rxd;
    logic       drv_en;
    logic [7:0] drv_data;
    wire  [7:0] databus;

    assign databus = drv_en ? drv_data : 8'hzz;

    spart_core_if bus();

    spart_core dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .databus (databus),
        .txd     (txd),
        .rxd     (rxd)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: divisor, receive buffer, rda flag
    logic [15:0] m_div;
    logic [7:0]  m_rx_buf;
    logic        m_rda;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.iocs = 1'b1; bus.iorw = 1'b0; bus.ioaddr = a;
        drv_data = d; drv_en = 1'b1;
        @(negedge clk);
        bus.iocs = 1'b0; drv_en = 1'b0;
        $display("wr  addr %0d data %02h", a, d);
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
        @(negedge clk);
        bus.iocs = 1'b1; bus.iorw = 1'b1; bus.ioaddr = a; drv_en = 1'b0;
        #1 d = databus;
        @(negedge clk);
        bus.iocs = 1'b0; bus.iorw = 1'b0;
        $display("rd  addr %0d data %02h", a, d);
    endtask

    task automatic set_div(input logic [15:0] d);
        bus_write(2'b10, d[7:0]);
        bus_write(2'b11, d[15:8]);
        m_div = d;
    endtask

    task automatic wait_until(input int unsigned target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic tx_frame(input logic [7:0] d, input bit inject);
        int unsigned bitlen, t_fall, t_rise;
        logic [9:0]  frame;
        bit          seen;
        bitlen = 16 * (int'(m_div) + 1);
        bus_write(2'b00, d);
        check("tbr_clr", bus.tbr, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 4 * bitlen && !seen; i++) begin
            if (txd == 1'b0) seen = 1'b1;
            else @(negedge clk);
        end
        check("tx_start", seen, 1'b1);
        t_fall = cyc;
        if (inject) bus_write(2'b00, 8'h3C);
        for (int i = 0; i < 10; i++) begin
            wait_until(t_fall + bitlen / 2 + i * bitlen);
            frame[i] = txd;
        end
        check("tx_frame", frame, {1'b1, d, 1'b0});
        seen = 1'b0;
        for (int i = 0; i < 2 * bitlen && !seen; i++) begin
            if (bus.tbr) seen = 1'b1;
            else @(negedge clk);
        end
        t_rise = cyc;
        check("tbr_set", seen, 1'b1);
        check("tx_len", t_rise - t_fall, 10 * bitlen);
        $display("tx  data %02h div %0d frame %03h len %0d", d, m_div, frame, t_rise - t_fall);
    endtask

    task automatic rx_frame(input logic [7:0] d, input logic stop_bit);
        int unsigned bitlen;
        bitlen = 16 * (int'(m_div) + 1);
        @(negedge clk);
        rxd = 1'b0;
        repeat (bitlen) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            repeat (bitlen) @(negedge clk);
        end
        rxd = stop_bit;
        repeat (3 * bitlen / 4) @(negedge clk);
        rxd = 1'b1;
        repeat (2 * bitlen) @(negedge clk);
        if (stop_bit) begin
            m_rx_buf = d;
            m_rda    = 1'b1;
        end
        $display("rx  data %02h stop %0b", d, stop_bit);
        check("rda", bus.rda, m_rda);
    endtask

    task automatic read_rx();
        logic [7:0] v;
        bus_read(2'b00, v);
        check("rx_data", v, m_rx_buf);
        m_rda = 1'b0;
        check("rda_clr", bus.rda, m_rda);
    endtask

    task automatic read_status();
        logic [7:0] v;
        bus_read(2'b01, v);
        check("status", v, {6'b0, 1'b1, m_rda});
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] v;
        logic [7:0] d;
        bit         stop_ok;
        rst = 1'b1; rxd = 1'b1; drv_en = 1'b0; drv_data = 8'h00;
        bus.iocs = 1'b0; bus.iorw = 1'b0; bus.ioaddr = 2'b00;
        m_div = 16'h0516; m_rx_buf = 8'h00; m_rda = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state and address map
        check("txd_reset", txd, 1'b1);
        read_status();
        bus_read(2'b10, v); check("rd_div_lo", v, 8'h00);
        bus_read(2'b11, v); check("rd_div_hi", v, 8'h00);
        bus_read(2'b00, v); check("rx_buf_reset", v, 8'h00);
        bus_write(2'b01, 8'hFF);
        read_status();

        // Transmit, with an ignored write while busy
        set_div(16'd3);
        tx_frame(8'hA5, 1'b1);
        begin
            bit saw_low;
            saw_low = 1'b0;
            repeat (3 * 64) begin
                @(negedge clk);
                if (!txd) saw_low = 1'b1;
            end
            check("no_2nd_frame", saw_low, 1'b0);
        end
        for (int k = 0; k < 3; k++) begin
            set_div(16'($urandom_range(0, 4)));
            tx_frame(8'($urandom), 1'b0);
        end

        // Receive
        set_div(16'd3);
        rx_frame(8'h5A, 1'b1);
        read_status();
        read_rx();

        @(negedge clk); rxd = 1'b0;
        repeat (20) @(negedge clk); rxd = 1'b1;
        repeat (200) @(negedge clk);
        check("glitch_rda", bus.rda, m_rda);
        rx_frame(8'hC3, 1'b1);
        read_rx();

        rx_frame(8'h96, 1'b0);
        read_status();

        rx_frame(8'h11, 1'b1);
        rx_frame(8'h22, 1'b1);
        read_status();
        read_rx();

        for (int k = 0; k < 5; k++) begin
            d       = 8'($urandom);
            stop_ok = ($urandom_range(0, 3) != 0);
            rx_frame(d, stop_ok);
            if ($urandom_range(0, 1) == 1) read_rx();
            else read_status();
        end

        // Reset in the middle of a transmission
        rx_frame(8'h77, 1'b1);
        bus_write(2'b00, 8'($urandom));
        repeat (150) @(negedge clk);
        check("tx_busy", txd === 1'b1 && bus.tbr === 1'b0 ? 1'b0 : bus.tbr, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_txd", txd, 1'b1);
        check("rst_tbr", bus.tbr, 1'b1);
        check("rst_rda", bus.rda, 1'b0);
        rst = 1'b0;
        m_rda = 1'b0; m_rx_buf = 8'h00; m_div = 16'h0516;
        read_status();
        bus_read(2'b00, v); check("rst_rx_buf", v, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
